// File: rtl/mcycle_sequencer.sv
// Iterative shift-add multiplier / restoring divider for the Execute stage, one step per cycle.
// Latency WIDTH+1 cycles of Busy, then a one-cycle Done; Busy stalls ID/EX and earlier stages.
module mcycle_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MCycleStartE,
    input  logic [1:0]       MCycleOpE,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic            is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0] addend, hi, lo, op1_raw;

    logic             sgn, s1, s2, last;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   sum, shifted;
    logic [WIDTH-1:0] diff, hi_n, lo_n, quo_fix, rem_fix;
    logic             ge;
    logic [2*WIDTH-1:0] full, prod_fix;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        last      = (count == CW'(WIDTH-1));
        case (state)
            IDLE: begin
                Busy = MCycleStartE;
                if (MCycleStartE) state_nxt = COMPUTING;
            end
            COMPUTING: begin
                Busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            // Start is still asserted here (ID/EX was frozen); it belongs to the op just finished.
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture: unsigned magnitudes, signs remembered for the final fix-up
    always_comb begin
        sgn  = ~MCycleOpE[0];
        s1   = sgn & Operand1[WIDTH-1];
        s2   = sgn & Operand2[WIDTH-1];
        mag1 = s1 ? -Operand1 : Operand1;
        mag2 = s2 ? -Operand2 : Operand2;
    end

    // One iteration: mul shifts {hi,lo} right after a conditional add, div shifts left and trial-subtracts
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
        shifted = {hi, lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, addend});
        diff    = shifted[WIDTH-1:0] - addend;
        if (is_div) begin
            hi_n = ge ? diff : shifted[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
        full     = {hi_n, lo_n};
        prod_fix = neg_q ? -full : full;
        quo_fix  = neg_q ? -lo_n : lo_n;
        rem_fix  = neg_r ? -hi_n : hi_n;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            addend   <= '0;
            hi       <= '0;
            lo       <= '0;
            op1_raw  <= '0;
            Result1  <= '0;
            Result2  <= '0;
        end else begin
            case (state)
                IDLE: if (MCycleStartE) begin
                    count    <= '0;
                    is_div   <= MCycleOpE[1];
                    neg_q    <= s1 ^ s2;
                    neg_r    <= s1;
                    div_zero <= MCycleOpE[1] && (Operand2 == '0);
                    addend   <= MCycleOpE[1] ? mag2 : mag1;
                    lo       <= MCycleOpE[1] ? mag1 : mag2;
                    hi       <= '0;
                    op1_raw  <= Operand1;
                end
                COMPUTING: begin
                    count <= count + 1'b1;
                    hi    <= hi_n;
                    lo    <= lo_n;
                    if (last) begin
                        if (!is_div) begin
                            Result1 <= prod_fix[WIDTH-1:0];
                            Result2 <= prod_fix[2*WIDTH-1:WIDTH];
                        end else if (div_zero) begin
                            Result1 <= '1;
                            Result2 <= op1_raw;
                        end else begin
                            Result1 <= quo_fix;
                            Result2 <= rem_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed and random multiply/divide operations through mcycle_sequencer with a result scoreboard.
// Latency, hold-through-DONE, back-to-back and mid-op reset are exercised.
module tb_mcycle_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [1:0]  op;
    logic [31:0] o1, o2, r1, r2;
    logic        busy, done;

    int checks = 0;
    int passed = 0;
    logic [63:0] exp_q[$];

    always #5 CLK = ~CLK;

    mcycle_sequencer #(.WIDTH(32)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MCycleStartE (start),
        .MCycleOpE    (op),
        .Operand1     (o1),
        .Operand2     (o2),
        .Busy         (busy),
        .Done         (done),
        .Result1      (r1),
        .Result2      (r2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Reference result packed as {Result2, Result1}
    function automatic logic [63:0] model(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq, sr;
        case (opc)
            2'b00: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Drives one op in the cycle after the current edge; leaves the bench positioned in the Done cycle.
    task automatic run_op(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input bit hold);
        int busy_cnt;
        bit seen;
        logic [63:0] ev;
        busy_cnt = 0;
        seen     = 0;
        @(posedge CLK); #1;
        start = 1'b1; op = opc; o1 = a; o2 = b;
        exp_q.push_back(e);
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge CLK);
            if (cyc == 0) chk("busy_at_start", busy, 1);
            if (done) begin
                seen = 1;
                chk("busy_cycles", busy_cnt, 33);
                chk("busy_at_done", busy, 0);
                ev = exp_q.pop_front();
                chk("result1", r1, ev[31:0]);
                chk("result2", r2, ev[63:32]);
            end else begin
                if (busy) busy_cnt++;
                @(posedge CLK); #1;
                if (!hold) begin
                    start = 1'b0;
                    o1 = $urandom;
                    o2 = $urandom;
                    op = 2'($urandom);
                end
            end
        end
        chk("done_seen", seen, 1);
    endtask

    initial begin
        int extra;
        logic [31:0] a, b;
        logic [1:0]  opc;

        RESET = 1'b1; start = 1'b0; op = 2'b00; o1 = '0; o2 = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_r1", r1, 0);
        chk("reset_r2", r2, 0);
        RESET = 1'b0;

        run_op(2'b00, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0);
        run_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
        run_op(2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 0);
        run_op(2'b11, 32'hDEADBEEF, 32'd0, {32'hDEADBEEF, 32'hFFFFFFFF}, 0);
        run_op(2'b10, 32'hFFFFFFF0, 32'd0, {32'hFFFFFFF0, 32'hFFFFFFFF}, 0);
        run_op(2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 64'd30, 0);
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 0);

        // Start held through DONE, then a second op with no bubble, then nothing more
        run_op(2'b01, 32'd1000, 32'd3000, 64'd3000000, 1);
        run_op(2'b11, 32'd1000, 32'd3, {32'd1, 32'd333}, 0);
        @(posedge CLK); #1;
        start = 1'b0;
        extra = 0;
        repeat (5) begin
            @(negedge CLK);
            if (busy || done) extra++;
        end
        chk("no_extra_op", extra, 0);
        chk("results_held", {r2, r1}, {32'd1, 32'd333});

        // Synchronous reset partway through an op
        @(posedge CLK); #1;
        start = 1'b1; op = 2'b01; o1 = 32'h12345678; o2 = 32'h9ABCDEF0;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        chk("busy_mid_op", busy, 1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_r1", r1, 0);
        chk("midreset_r2", r2, 0);
        run_op(2'b01, 32'h12345678, 32'h9ABCDEF0, model(2'b01, 32'h12345678, 32'h9ABCDEF0), 0);

        for (int i = 0; i < 8; i++) begin
            a   = $urandom;
            b   = $urandom;
            opc = 2'(i % 4);
            if (opc[1] && (i % 8) >= 4) b = b >> 20;
            if (b == 32'd0) b = 32'd1;
            run_op(opc, a, b, model(opc, a, b), 0);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
